// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction-memory addressing and IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_WORDS = 1024,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);
  logic [31:0] pc_plus4;
  assign pc_plus4 = pc + 32'd4;
  assign imem_address = (pc >> 2) & 32'(MEM_WORDS - 1);
  always_ff @(posedge clk) begin
    if (rst || redirect || flush) begin
      if_id_instruction <= NOP;
      if_id_pc <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_instruction <= imem_instruction;
      if_id_pc <= pc;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid <= 1'b1;
    end
    if (rst) begin
      pc <= {RESET_PC[31:2], 2'b00};
      fetch_count <= '0;
    end else if (redirect) begin
      pc <= {redirect_target[31:2], 2'b00};
    end else if (!stall) begin
      pc <= pc_plus4;
      // a flushed fetch is discarded, so only an accepted word counts
      if (!flush) fetch_count <= fetch_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of reset, sequential fetch, stall, flush, redirect and PC wrap.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst, stall, flush, redirect;
  logic [31:0] redirect_target, imem_address, imem_instruction, pc;
  logic [31:0] if_id_instruction, if_id_pc, if_id_pc_plus4, fetch_count;
  logic if_id_valid;
  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;
  logic [192:0] obs;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_target(redirect_target), .imem_address(imem_address),
    .imem_instruction(imem_instruction), .pc(pc),
    .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count)
  );

  assign imem_instruction = mem[imem_address[9:0]];
  assign obs = {pc, imem_address, if_id_instruction, if_id_pc, if_id_pc_plus4, if_id_valid, fetch_count};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0; redirect = 0; redirect_target = 0;
    step(); step();
    checks++;
    if (obs !== {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL reset got %h expected reset state", obs);
    end
  endtask

  task automatic test_run();
    rst = 0;
    step();
    checks++;
    if (obs !== {32'h4, 32'h1, 32'h8C0A0020, 32'h0, 32'h4, 1'b1, 32'd1}) begin
      errors++; $display("FAIL run_1 got %h", obs);
    end
    step();
    checks++;
    if (obs !== {32'h8, 32'h2, 32'h8C0A0021, 32'h4, 32'h8, 1'b1, 32'd2}) begin
      errors++; $display("FAIL run_2 got %h", obs);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== {32'h8, 32'h2, 32'h8C0A0021, 32'h4, 32'h8, 1'b1, 32'd2}) begin
        errors++; $display("FAIL stall_%0d got %h", i, obs);
      end
    end
    stall = 0;
    step();
    checks++;
    if (obs !== {32'hC, 32'h3, 32'h0, 32'h8, 32'hC, 1'b1, 32'd3}) begin
      errors++; $display("FAIL stall_release got %h", obs);
    end
  endtask

  task automatic test_redirect();
    redirect = 1; redirect_target = 32'h16;
    step();
    checks++;
    if (obs !== {32'h14, 32'h5, 32'h0, 32'h0, 32'h0, 1'b0, 32'd3}) begin
      errors++; $display("FAIL redirect_bubble got %h", obs);
    end
    redirect = 0;
    step();
    checks++;
    if (obs !== {32'h18, 32'h6, 32'hA0000005, 32'h14, 32'h18, 1'b1, 32'd4}) begin
      errors++; $display("FAIL redirect_target_word got %h", obs);
    end
  endtask

  task automatic test_priority();
    redirect = 1; stall = 1; flush = 1; redirect_target = 32'h20;
    step();
    checks++;
    if (obs !== {32'h20, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0, 32'd4}) begin
      errors++; $display("FAIL redirect_stall_flush got %h", obs);
    end
    redirect = 0; stall = 0; flush = 1;
    step();
    checks++;
    if (obs !== {32'h24, 32'h9, 32'h0, 32'h0, 32'h0, 1'b0, 32'd4}) begin
      errors++; $display("FAIL flush_only got %h", obs);
    end
    flush = 0;
    step();
    checks++;
    if (obs !== {32'h28, 32'hA, 32'hA0000009, 32'h24, 32'h28, 1'b1, 32'd5}) begin
      errors++; $display("FAIL after_flush got %h", obs);
    end
    stall = 1; flush = 1;
    step();
    checks++;
    if (obs !== {32'h28, 32'hA, 32'h0, 32'h0, 32'h0, 1'b0, 32'd5}) begin
      errors++; $display("FAIL stall_flush got %h", obs);
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_target = 32'h1000;
    step();
    checks++;
    if (obs !== {32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd5}) begin
      errors++; $display("FAIL addr_wrap got %h", obs);
    end
    redirect = 0;
    step();
    checks++;
    if (obs !== {32'h1004, 32'h1, 32'h8C0A0020, 32'h1000, 32'h1004, 1'b1, 32'd6}) begin
      errors++; $display("FAIL addr_wrap_fetch got %h", obs);
    end
    redirect = 1; redirect_target = 32'hFFFF_FFFF;
    step();
    checks++;
    if (obs !== {32'hFFFF_FFFC, 32'h3FF, 32'h0, 32'h0, 32'h0, 1'b0, 32'd6}) begin
      errors++; $display("FAIL redirect_mask got %h", obs);
    end
    redirect = 0;
    step();
    checks++;
    if (obs !== {32'h0, 32'h0, 32'hA00003FF, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd7}) begin
      errors++; $display("FAIL pc_wrap got %h", obs);
    end
  endtask

  task automatic test_reset_mid();
    step();
    checks++;
    if (obs !== {32'h4, 32'h1, 32'h8C0A0020, 32'h0, 32'h4, 1'b1, 32'd8}) begin
      errors++; $display("FAIL pre_reset_run got %h", obs);
    end
    stall = 1;
    step();
    checks++;
    if (obs !== {32'h4, 32'h1, 32'h8C0A0020, 32'h0, 32'h4, 1'b1, 32'd8}) begin
      errors++; $display("FAIL pre_reset_stall got %h", obs);
    end
    rst = 1;
    step();
    checks++;
    if (obs !== {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL reset_mid got %h", obs);
    end
    rst = 0; stall = 0;
    step();
    checks++;
    if (obs !== {32'h4, 32'h1, 32'h8C0A0020, 32'h0, 32'h4, 1'b1, 32'd1}) begin
      errors++; $display("FAIL restart got %h", obs);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h8C0A0020;
    mem[1] = 32'h8C0A0021;
    mem[2] = 32'h0;
    mem[3] = 32'h0;
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_priority();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
